muldiv_unit: RTL

- Iterative multiply/divide unit for the RV32M extension, parametrised in operand width and bits retired per cycle.
- Sits beside the ALU in the execute stage. Accepts one operation per request handshake and returns the result with its destination-register tag.
- The pipeline stalls on req_ready_o / resp_valid_o.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_step.sv | 41 ++++
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  function automatic int iter_count(input int xlen, input int bpc);
    return xlen / bpc;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One CALC cycle: BPC MSB-first shift-add (multiply) or restoring-subtract (divide) steps.
module muldiv_step #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic              div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opa_i,
  input  logic [XLEN-1:0]   opb_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [XLEN-1:0]   opb_o
);

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;
  logic [XLEN:0]     rem;
  logic              ge;

  // Divide keeps {remainder, dividend/quotient} in acc; multiply shifts the multiplier out of opb.
  always_comb begin
    acc = acc_i;
    opb = opb_i;
    rem = '0;
    ge  = 1'b0;
    for (int i = 0; i < BPC; i++) begin
      if (div_i) begin
        rem = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        ge  = (rem >= {1'b0, opb});
        if (ge) rem = rem - {1'b0, opb};
        acc = {rem[XLEN-1:0], acc[XLEN-2:0], ge};
      end else begin
        acc = {acc[2*XLEN-2:0], 1'b0} +
              {{XLEN{1'b0}}, (opb[XLEN-1] ? opa_i : {XLEN{1'b0}})};
        opb = {opb[XLEN-2:0], 1'b0};
      end
    end
    acc_o = acc;
    opb_o = opb;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude iteration, then one sign-fix cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 1,
  parameter int TAGW = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [TAGW-1:0] tag_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [TAGW-1:0] tag_o
);

  localparam int N  = iter_count(XLEN, BPC);
  localparam int CW = $clog2(N + 1);

  state_e            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [TAGW-1:0]   tag_lat_q, tag_lat_d, tag_q, tag_d;
  logic              sign_q, sign_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [2*XLEN-1:0] step_acc, prod_fix;
  logic [XLEN-1:0]   step_opb, div_sel, div_fix, mag1, mag2;
  logic              accept, is_div, s1, s2, neg1, neg2, div0, ovf;

  muldiv_step #(.XLEN(XLEN), .BPC(BPC)) u_step (
    .div_i (f3_q[2]),
    .acc_i (acc_q),
    .opa_i (opa_q),
    .opb_i (opb_q),
    .acc_o (step_acc),
    .opb_o (step_opb)
  );

  assign accept = req_valid_i & (state_q == S_IDLE) & ~flush_i;
  assign is_div = funct3_i[2];
  assign s1     = (funct3_i == MD_MULH) | (funct3_i == MD_MULHSU) |
                  (funct3_i == MD_DIV)  | (funct3_i == MD_REM);
  assign s2     = (funct3_i == MD_MULH) | (funct3_i == MD_DIV) | (funct3_i == MD_REM);
  assign neg1   = s1 & rs1_i[XLEN-1];
  assign neg2   = s2 & rs2_i[XLEN-1];
  assign mag1   = neg1 ? -rs1_i : rs1_i;
  assign mag2   = neg2 ? -rs2_i : rs2_i;
  assign div0   = is_div & (rs2_i == '0);
  assign ovf    = is_div & s2 & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_i);

  assign prod_fix = sign_q ? -acc_q : acc_q;
  assign div_sel  = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign div_fix  = sign_q ? -div_sel : div_sel;

  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    tag_lat_d = tag_lat_q;
    tag_d     = tag_q;
    sign_d    = sign_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        f3_d      = funct3_i;
        tag_lat_d = tag_i;
        sign_d    = (is_div & funct3_i[1]) ? neg1 : (neg1 ^ neg2);
        opa_d     = mag1;
        opb_d     = mag2;
        cnt_d     = '0;
        acc_d     = is_div ? {{XLEN{1'b0}}, mag1} : '0;
        // Zero divisor and signed overflow have fixed answers, so skip iteration.
        if (div0 | ovf) begin
          state_d = S_DONE;
          tag_d   = tag_i;
          if (div0) result_d = funct3_i[1] ? rs1_i : '1;
          else      result_d = funct3_i[1] ? '0 : rs1_i;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        opb_d = step_opb;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        tag_d   = tag_lat_q;
        if (f3_q[2])              result_d = div_fix;
        else if (f3_q == MD_MUL)  result_d = prod_fix[XLEN-1:0];
        else                      result_d = prod_fix[2*XLEN-1:XLEN];
      end
      S_DONE: if (resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      f3_q      <= '0;
      tag_lat_q <= '0;
      tag_q     <= '0;
      sign_q    <= 1'b0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      tag_lat_q <= tag_lat_d;
      tag_q     <= tag_d;
      sign_q    <= sign_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
    end
  end

  // Ready is held low while reset is asserted so every output reads zero in reset.
  assign req_ready_o  = (state_q == S_IDLE) & rst_i;
  assign resp_valid_o = (state_q == S_DONE);
  assign result_o     = result_q;
  assign tag_o        = tag_q;

endmodule
